// File: rtl/call_stack_if.sv
// call_stack_if -- push/pop bus between the datapath and the return-address
// stack.
//
// Parameters:
//   WIDTH  bit width of a stored return address (matches the PC width)
//   DEPTH  number of stack entries; the occupancy width CW is derived from it
//
// Signals:
//   s_push     push din this cycle (jal)
//   s_pop      pop the top entry this cycle (ret)
//   din        address to push (PC+1)
//   s_clr_err  clears the sticky error flags
//   dout       current top of stack, or zero when the stack is empty
//   empty      no valid entries
//   full       DEPTH valid entries
//   count      number of valid entries
//   ovf        sticky overflow flag
//   udf        sticky underflow flag
//
// Modports:
//   master  the datapath side; drives requests and observes state
//   slave   the stack itself
interface call_stack_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             s_push;
  logic             s_pop;
  logic [WIDTH-1:0] din;
  logic             s_clr_err;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             udf;

  modport master (
    output s_push, s_pop, din, s_clr_err,
    input  dout, empty, full, count, ovf, udf
  );

  modport slave (
    input  s_push, s_pop, din, s_clr_err,
    output dout, empty, full, count, ovf, udf
  );
endinterface

// File: rtl/call_stack.sv
// call_stack -- parametrised return-address stack for the single-cycle
// datapath. It takes push data from the PC incrementer and presents its top
// entry to the jump-address mux.
//
// Parameters:
//   WIDTH  bit width of each stored address
//   DEPTH  number of entries (power of two, >= 2)
//   WRAP   0: a push on a full stack is rejected
//          1: a push on a full stack overwrites the oldest entry
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears pointer, count and error flags
//   bus    call_stack_if slave modport (push/pop/din/clear in,
//          dout/empty/full/count/ovf/udf out)
//
// The storage is a circular buffer addressed by a write pointer wp. The top
// of stack always lives at wp-1, so push, pop and replace-top are single-cycle
// updates of wp/count plus at most one array write. dout is read
// combinationally, which lets the datapath use it as the return address in
// the same cycle as the pop.
module call_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0
) (
  input  logic       clk,
  input  logic       reset,
  call_stack_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  // Pointer arithmetic relies on the AW-bit pointer wrapping naturally, which
  // is why DEPTH must be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return p - AW'(1);
  endfunction

  // Storage holds data only; it is never reset because dout masks it
  // whenever the stack is empty.
  logic [WIDTH-1:0] mem [DEPTH];

  // Control state.
  logic [AW-1:0] wp;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic          udf_q;

  // Next-state decode.
  logic          is_empty;
  logic          is_full;
  logic [AW-1:0] top_idx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] wp_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_set;
  logic          udf_set;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));
  assign top_idx  = ptr_dec(wp);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wp;
    wp_nxt  = wp;
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    udf_set = 1'b0;

    unique case ({bus.s_push, bus.s_pop})
      2'b10: begin
        if (!is_full) begin
          wr_en   = 1'b1;
          wp_nxt  = ptr_inc(wp);
          cnt_nxt = cnt + CW'(1);
        end else begin
          ovf_set = 1'b1;
          // When full, wp points at the oldest entry, so writing there and
          // advancing the pointer drops exactly that entry.
          if (WRAP != 0) begin
            wr_en  = 1'b1;
            wp_nxt = ptr_inc(wp);
          end
        end
      end
      2'b01: begin
        // A pop only moves the pointer; the stale entry stays in the array
        // but is no longer reachable.
        if (!is_empty) begin
          wp_nxt  = ptr_dec(wp);
          cnt_nxt = cnt - CW'(1);
        end else begin
          udf_set = 1'b1;
        end
      end
      2'b11: begin
        // Simultaneous jal/ret: replace the top in place. On an empty stack
        // there is nothing to replace, so it degenerates into a push.
        wr_en = 1'b1;
        if (!is_empty) begin
          wr_addr = top_idx;
        end else begin
          wp_nxt  = ptr_inc(wp);
          cnt_nxt = CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Control registers; reset takes priority over any request in the cycle.
  // A new error event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wp    <= wp_nxt;
      cnt   <= cnt_nxt;
      ovf_q <= ovf_set | (ovf_q & ~bus.s_clr_err);
      udf_q <= udf_set | (udf_q & ~bus.s_clr_err);
    end
  end

  // A write that lands in the same cycle as reset is harmless: the entry is
  // unreachable once count returns to zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.din;
    end
  end

  assign bus.dout  = is_empty ? '0 : mem[top_idx];
  assign bus.empty = is_empty;
  assign bus.full  = is_full;
  assign bus.count = cnt;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;

endmodule
